// File: rtl/mpmc11_app_responder.sv
// Block-RAM backed responder for the MIG-style native app interface driven by mpmc11.
// Models calibration delay, command back-pressure, write-data pairing, fixed read latency and refresh.
module mpmc11_app_responder #(
    parameter int DW           = 256,
    parameter int AW           = 12,
    parameter int APP_AW       = 29,
    parameter int ASH          = 3,
    parameter int CQ_DEPTH     = 4,
    parameter int WDF_DEPTH    = 4,
    parameter int RD_LAT       = 4,
    parameter int CALIB_CYCLES = 64,
    parameter int REF_CYCLES   = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_calib_complete,
    input  logic              app_en,
    input  logic [2:0]        app_cmd,
    input  logic [APP_AW-1:0] app_addr,
    output logic              app_rdy,
    input  logic              app_wdf_wren,
    input  logic [DW-1:0]     app_wdf_data,
    input  logic [DW/8-1:0]   app_wdf_mask,
    input  logic              app_wdf_end,
    output logic              app_wdf_rdy,
    output logic [DW-1:0]     app_rd_data,
    output logic              app_rd_data_valid,
    output logic              app_rd_data_end,
    input  logic              app_ref_req,
    output logic              app_ref_ack
);

    localparam int CQ_AW   = $clog2(CQ_DEPTH);
    localparam int WQ_AW   = $clog2(WDF_DEPTH);
    localparam int BW      = DW / 8;
    localparam int CNT_MAX = (CALIB_CYCLES > REF_CYCLES) ? CALIB_CYCLES : REF_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CQ_AW:0]     CQ_FULL    = (CQ_AW + 1)'(CQ_DEPTH);
    localparam logic [WQ_AW:0]     WQ_FULL    = (WQ_AW + 1)'(WDF_DEPTH);
    localparam logic [CNT_W-1:0]   CALIB_LAST = CNT_W'(CALIB_CYCLES - 1);
    localparam logic [CNT_W-1:0]   REF_LAST   = CNT_W'(REF_CYCLES - 1);
    localparam logic [2:0]         CMD_WR     = 3'b000;
    localparam logic [2:0]         CMD_RD     = 3'b001;

    typedef enum logic [1:0] {S_CALIB, S_RUN, S_REFRESH} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             ref_pend;

    logic [2:0]       cq_cmd [CQ_DEPTH];
    logic [AW-1:0]    cq_idx [CQ_DEPTH];
    logic [CQ_AW-1:0] cq_wp, cq_rp;
    logic [CQ_AW:0]   cq_count;

    logic [DW-1:0]    wq_data [WDF_DEPTH];
    logic [BW-1:0]    wq_mask [WDF_DEPTH];
    logic [WQ_AW-1:0] wq_wp, wq_rp;
    logic [WQ_AW:0]   wq_count;

    logic [DW-1:0]    mem [2**AW];
    logic             vld_p  [RD_LAT];
    logic [DW-1:0]    data_p [RD_LAT];

    logic             cq_push, cq_pop, cq_valid;
    logic             wq_push, wq_pop, wq_valid;
    logic             exec_wr, exec_rd;
    logic [2:0]       head_cmd;
    logic [AW-1:0]    head_idx;

    // Burst-end flag and address bits outside the beat index carry no information here.
    logic unused_ok;
    assign unused_ok = ^{app_wdf_end, app_addr[APP_AW-1:AW+ASH], app_addr[ASH-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= S_CALIB;
            cnt                 <= '0;
            init_calib_complete <= 1'b0;
        end else begin
            state               <= state_nxt;
            cnt                 <= (state_nxt != state || state == S_RUN) ? '0 : cnt + CNT_W'(1);
            init_calib_complete <= (state_nxt != S_CALIB);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_CALIB:   if (cnt == CALIB_LAST) state_nxt = S_RUN;
            S_RUN:     if (ref_pend && cq_count == '0) state_nxt = S_REFRESH;
            S_REFRESH: if (cnt == REF_LAST) state_nxt = S_RUN;
            default:   state_nxt = S_CALIB;
        endcase
    end

    always_comb begin
        app_rdy     = (state == S_RUN) && !ref_pend && (cq_count != CQ_FULL);
        app_ref_ack = (state == S_REFRESH) && (cnt == REF_LAST);
    end

    assign app_wdf_rdy = init_calib_complete && (wq_count != WQ_FULL);

    // Requests arriving while one is already pending fold into it.
    always_ff @(posedge clk) begin
        if (rst)
            ref_pend <= 1'b0;
        else if (state == S_RUN && ref_pend && cq_count == '0)
            ref_pend <= 1'b0;
        else if (app_ref_req)
            ref_pend <= 1'b1;
    end

    assign cq_push  = app_en && app_rdy;
    assign wq_push  = app_wdf_wren && app_wdf_rdy;
    assign head_cmd = cq_cmd[cq_rp];
    assign head_idx = cq_idx[cq_rp];
    assign cq_valid = (cq_count != '0);
    assign wq_valid = (wq_count != '0);
    assign exec_wr  = cq_valid && (head_cmd == CMD_WR) && wq_valid;
    assign exec_rd  = cq_valid && (head_cmd == CMD_RD);
    assign cq_pop   = cq_valid && ((head_cmd != CMD_WR) || wq_valid);
    assign wq_pop   = exec_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            cq_wp    <= '0;
            cq_rp    <= '0;
            cq_count <= '0;
            wq_wp    <= '0;
            wq_rp    <= '0;
            wq_count <= '0;
        end else begin
            if (cq_push) cq_wp <= cq_wp + CQ_AW'(1);
            if (cq_pop)  cq_rp <= cq_rp + CQ_AW'(1);
            if (wq_push) wq_wp <= wq_wp + WQ_AW'(1);
            if (wq_pop)  wq_rp <= wq_rp + WQ_AW'(1);
            case ({cq_push, cq_pop})
                2'b10:   cq_count <= cq_count + (CQ_AW + 1)'(1);
                2'b01:   cq_count <= cq_count - (CQ_AW + 1)'(1);
                default: cq_count <= cq_count;
            endcase
            case ({wq_push, wq_pop})
                2'b10:   wq_count <= wq_count + (WQ_AW + 1)'(1);
                2'b01:   wq_count <= wq_count - (WQ_AW + 1)'(1);
                default: wq_count <= wq_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (cq_push) begin
            cq_cmd[cq_wp] <= app_cmd;
            cq_idx[cq_wp] <= app_addr[AW+ASH-1:ASH];
        end
        if (wq_push) begin
            wq_data[wq_wp] <= app_wdf_data;
            wq_mask[wq_wp] <= app_wdf_mask;
        end
    end

    // Stage p0: RAM access at execution; later stages only delay the returned beat.
    always_ff @(posedge clk) begin
        if (exec_wr && !rst) begin
            for (int b = 0; b < BW; b++) begin
                if (!wq_mask[wq_rp][b])
                    mem[head_idx][b*8 +: 8] <= wq_data[wq_rp][b*8 +: 8];
            end
        end
        data_p[0] <= mem[head_idx];
        for (int i = 1; i < RD_LAT; i++)
            data_p[i] <= data_p[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++)
                vld_p[i] <= 1'b0;
        end else begin
            vld_p[0] <= exec_rd;
            for (int i = 1; i < RD_LAT; i++)
                vld_p[i] <= vld_p[i-1];
        end
    end

    assign app_rd_data_valid = vld_p[RD_LAT-1];
    assign app_rd_data_end   = vld_p[RD_LAT-1];
    assign app_rd_data       = vld_p[RD_LAT-1] ? data_p[RD_LAT-1] : '0;

endmodule

// File: tb/tb_mpmc11_app_responder.sv
// Directed bench for mpmc11_app_responder: calibration, write/read pairing, masks,
// queue back-pressure, refresh and reset with reads in flight.
module tb_mpmc11_app_responder;

    localparam int DW     = 256;
    localparam int AW     = 12;
    localparam int APP_AW = 29;
    localparam int RD_LAT = 4;
    localparam logic [2:0] WR = 3'b000;
    localparam logic [2:0] RD = 3'b001;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              init_calib_complete;
    logic              app_en = 1'b0;
    logic [2:0]        app_cmd = '0;
    logic [APP_AW-1:0] app_addr = '0;
    logic              app_rdy;
    logic              app_wdf_wren = 1'b0;
    logic [DW-1:0]     app_wdf_data = '0;
    logic [DW/8-1:0]   app_wdf_mask = '0;
    logic              app_wdf_end = 1'b1;
    logic              app_wdf_rdy;
    logic [DW-1:0]     app_rd_data;
    logic              app_rd_data_valid;
    logic              app_rd_data_end;
    logic              app_ref_req = 1'b0;
    logic              app_ref_ack;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mpmc11_app_responder #(
        .DW(DW), .AW(AW), .APP_AW(APP_AW), .ASH(3), .CQ_DEPTH(4), .WDF_DEPTH(4),
        .RD_LAT(RD_LAT), .CALIB_CYCLES(64), .REF_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete),
        .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
        .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
        .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(app_rd_data_end),
        .app_ref_req(app_ref_req), .app_ref_ack(app_ref_ack)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [2:0] c, input logic [APP_AW-1:0] a);
        int n;
        n = 0;
        app_en = 1'b1; app_cmd = c; app_addr = a;
        while (!app_rdy && n < 200) begin tick; n++; end
        if (n >= 200) chk("cmd_timeout", DW'(app_rdy), DW'(1));
        tick;
        app_en = 1'b0;
    endtask

    task automatic send_wdata(input logic [DW-1:0] d, input logic [DW/8-1:0] m);
        int n;
        n = 0;
        app_wdf_wren = 1'b1; app_wdf_data = d; app_wdf_mask = m;
        while (!app_wdf_rdy && n < 200) begin tick; n++; end
        if (n >= 200) chk("wdf_timeout", DW'(app_wdf_rdy), DW'(1));
        tick;
        app_wdf_wren = 1'b0;
    endtask

    // Called in the read's execution cycle (the cycle after it is accepted into an empty queue).
    task automatic expect_read(input string tag, input logic [DW-1:0] exp);
        int early;
        early = 0;
        repeat (RD_LAT - 1) begin tick; if (app_rd_data_valid) early++; end
        tick;
        chk({tag, "_early"}, DW'(early), DW'(0));
        chk({tag, "_valid"}, DW'(app_rd_data_valid), DW'(1));
        chk({tag, "_end"}, DW'(app_rd_data_end), DW'(1));
        chk({tag, "_data"}, app_rd_data, exp);
        tick;
        chk({tag, "_once"}, DW'(app_rd_data_valid), DW'(0));
    endtask

    // Called in the first cycle with rst low.
    task automatic calib_wait(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (init_calib_complete || app_rdy || app_rd_data_valid) bad++;
            tick;
        end
        chk({tag, "_low64"}, DW'(bad), DW'(0));
        chk({tag, "_done"}, DW'(init_calib_complete), DW'(1));
        chk({tag, "_rdy"}, DW'(app_rdy), DW'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] a5, mixed, d5a;
        logic [DW-1:0] dq [5];
        int bad, nv, v0_t, v1_t, ack_n, ack_t, rdy_t;
        logic [DW-1:0] v0_d, v1_d;
        logic wdf_in_ref;

        a5    = {32{8'hA5}};
        mixed = {{31{8'hFF}}, 8'h11};
        d5a   = {32{8'h5A}};
        for (int i = 0; i < 5; i++) dq[i] = {8{32'hC0DE_0000 | i}};

        rst = 1'b1;
        repeat (3) tick;
        chk("rst_calib", DW'(init_calib_complete), DW'(0));
        chk("rst_rdy", DW'(app_rdy), DW'(0));
        chk("rst_wdf_rdy", DW'(app_wdf_rdy), DW'(0));
        chk("rst_valid", DW'(app_rd_data_valid), DW'(0));
        chk("rst_ack", DW'(app_ref_ack), DW'(0));
        chk("rst_data", app_rd_data, DW'(0));
        rst = 1'b0;
        calib_wait("calib");
        chk("wdf_rdy_run", DW'(app_wdf_rdy), DW'(1));

        // Data two cycles ahead of its command, then read back.
        send_wdata(a5, '0);
        tick;
        send_cmd(WR, 29'h40);
        send_cmd(RD, 29'h40);
        expect_read("rd40", a5);

        // Command ahead of data, then a write masking byte 0.
        send_cmd(WR, 29'h8);
        send_wdata({32{8'h11}}, '0);
        send_cmd(WR, 29'h8);
        send_wdata({32{8'hFF}}, 32'h0000_0001);
        send_cmd(RD, 29'h8);
        expect_read("rd8_mask", mixed);

        // Unknown command is dropped; high and low address bits are ignored.
        send_cmd(3'b011, 29'h40);
        send_cmd(RD, 29'h1000_8047);
        expect_read("rd_alias", a5);

        // Queue fill with no write data.
        for (int i = 0; i < 4; i++) send_cmd(WR, APP_AW'(32'h100 + 8 * i));
        chk("cq_full_rdy", DW'(app_rdy), DW'(0));
        app_en = 1'b1; app_cmd = WR; app_addr = 29'h120;
        bad = 0;
        repeat (3) begin tick; if (app_rdy) bad++; end
        chk("cq_full_hold", DW'(bad), DW'(0));
        send_wdata(dq[0], '0);
        chk("rdy_at_pop", DW'(app_rdy), DW'(0));
        tick;
        chk("rdy_return", DW'(app_rdy), DW'(1));
        tick;
        app_en = 1'b0;
        for (int i = 1; i < 5; i++) send_wdata(dq[i], '0);
        repeat (4) tick;
        send_cmd(RD, 29'h100);
        expect_read("rd_q0", dq[0]);
        send_cmd(RD, 29'h120);
        expect_read("rd_q4", dq[4]);

        // Refresh requested while a data-starved write holds two reads behind it.
        send_cmd(WR, 29'h200);
        send_cmd(RD, 29'h40);
        send_cmd(RD, 29'h8);
        app_ref_req = 1'b1;
        tick;
        app_ref_req = 1'b0;
        chk("rdy_after_req", DW'(app_rdy), DW'(0));
        send_wdata(d5a, '0);
        nv = 0; v0_t = 0; v1_t = 0; ack_n = 0; ack_t = 0; rdy_t = 0;
        v0_d = '0; v1_d = '0; wdf_in_ref = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            if (app_rd_data_valid) begin
                if (nv == 0) begin v0_t = t; v0_d = app_rd_data; end
                else if (nv == 1) begin v1_t = t; v1_d = app_rd_data; end
                nv++;
            end
            if (app_ref_ack) begin ack_n++; ack_t = t; end
            if (app_rdy && rdy_t == 0) rdy_t = t;
            if (t == 8) wdf_in_ref = app_wdf_rdy;
            tick;
        end
        chk("ref_nvalid", DW'(nv), DW'(2));
        chk("ref_v0_t", DW'(v0_t), DW'(6));
        chk("ref_v0_d", v0_d, a5);
        chk("ref_v1_t", DW'(v1_t), DW'(7));
        chk("ref_v1_d", v1_d, mixed);
        chk("ref_ack_n", DW'(ack_n), DW'(1));
        chk("ref_ack_t", DW'(ack_t), DW'(12));
        chk("ref_rdy_t", DW'(rdy_t), DW'(13));
        chk("ref_wdf_rdy", DW'(wdf_in_ref), DW'(1));
        send_cmd(RD, 29'h200);
        expect_read("rd200", d5a);

        // Reset with three reads in the pipe.
        send_cmd(RD, 29'h40);
        send_cmd(RD, 29'h8);
        send_cmd(RD, 29'h200);
        tick;
        rst = 1'b1;
        bad = 0;
        repeat (3) begin tick; if (app_rd_data_valid) bad++; end
        chk("rst2_no_valid", DW'(bad), DW'(0));
        chk("rst2_calib", DW'(init_calib_complete), DW'(0));
        chk("rst2_data", app_rd_data, DW'(0));
        rst = 1'b0;
        calib_wait("recalib");
        send_cmd(RD, 29'h40);
        expect_read("rd40_kept", a5);
        send_cmd(RD, 29'h8);
        expect_read("rd8_kept", mixed);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mpmc11_app_responder.md
Name: mpmc11_app_responder

Overview:
Memory-side responder for the MIG-style native application interface that mpmc11 drives: app_en/app_cmd/app_addr, write-data FIFO, read data return, and refresh handshake. It is backed by an on-chip block RAM. It lets the mpmc11 controller run in simulation and on DDR-less boards. It reproduces calibration delay, command back-pressure, write-data pairing, fixed read latency and refresh acknowledge.

Parameters:
DW, 256, data beat width in bits (one app beat)
AW, 12, backing store index width (2^AW beats)
APP_AW, 29, app_addr width
ASH, 3, app_addr LSBs dropped to form beat index (index = app_addr[AW+ASH-1:ASH])
CQ_DEPTH, 4, command queue depth (power of 2)
WDF_DEPTH, 4, write-data FIFO depth (power of 2)
RD_LAT, 4, cycles from read execution to app_rd_data_valid (>=1)
CALIB_CYCLES, 64, cycles after reset before init_calib_complete
REF_CYCLES, 8, cycles spent in refresh

Ports:
clk  in  1  clock
rst  in  1  reset
init_calib_complete  out  1  calibration done
app_en  in  1  command strobe
app_cmd  in  3  3'b000 write, 3'b001 read, others ignored
app_addr  in  APP_AW  command address
app_rdy  out  1  command accepted when app_en&app_rdy
app_wdf_wren  in  1  write data strobe
app_wdf_data  in  DW  write data
app_wdf_mask  in  DW/8  byte mask, 1 = byte NOT written
app_wdf_end  in  1  last beat (always 1 for single-beat; ignored)
app_wdf_rdy  out  1  data accepted when app_wdf_wren&app_wdf_rdy
app_rd_data  out  DW  read data
app_rd_data_valid  out  1  read data strobe
app_rd_data_end  out  1  equals app_rd_data_valid
app_ref_req  in  1  refresh request pulse
app_ref_ack  out  1  one-cycle refresh done pulse

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. All outputs 0; state CALIB; queues, read pipe, ref latch and counters cleared. RAM contents are not cleared. Reset mid-operation discards in-flight reads and queued writes; no valid is issued for them.
- States:
  - CALIB: counter runs 0..CALIB_CYCLES-1, then RUN. init_calib_complete is registered high from the first RUN cycle and stays high until rst.
  - RUN: normal operation.
  - REFRESH: counter runs REF_CYCLES cycles. app_ref_ack pulses high for 1 cycle on exit to RUN.
- Refresh entry: app_ref_req sets ref_pend. A req arriving while ref_pend is already set is merged. RUN->REFRESH when ref_pend=1 and the command queue is empty; ref_pend clears on entry. Reads already in the read pipe still complete during REFRESH.
- app_rdy = (state==RUN) & !ref_pend & (cq_count<CQ_DEPTH), computed from registered state only, with no combinational path from app_en.
- app_wdf_rdy = init_calib_complete & (wdf_count<WDF_DEPTH). Data may arrive before or after its command. Write data is paired in order with write commands.
- Accepted commands enqueue {cmd, beat index}. Head execution, at most one per cycle:
  - write: executes only when the WDF is non-empty. It pops both queues and writes per unmasked byte.
  - read: executes immediately and enters an RD_LAT-stage shift pipe.
  - other cmd: popped with no action.
- Ordering is strictly in order, so a read after a write to the same index returns the new data.
- Simultaneous enqueue and dequeue on a full queue is not possible (app_rdy=0 when full). Enqueue and dequeue in the same cycle on a non-full queue leaves the count unchanged.
- Read return: app_rd_data_valid/app_rd_data_end are high exactly RD_LAT cycles after the execution cycle, one beat per read. Back-to-back reads give back-to-back valids. There is no back-pressure on read data.
- Index wraps modulo 2^AW; address bits above AW+ASH-1 are ignored.
- Commands are not accepted in CALIB or REFRESH. app_wdf_rdy stays high in REFRESH if there is space.

Test Plan:
- Reset, idle -> init_calib_complete=0 for 64 cycles and 1 from cycle 65. app_rdy=0 throughout CALIB.
- Write to addr 0x40 with data 0xA5.., mask 0, data presented 2 cycles before the command; then read 0x40 -> app_rd_data=0xA5.. with valid exactly 4 cycles after read execution.
- Write 0x11.. to addr 0x8, then a masked write with mask=1 on byte 0 only and data 0xFF..; read 0x8 -> byte0=0x11, all other bytes 0xFF.
- Issue 5 write commands with no data -> app_rdy drops after 4 accepted. Supplying data drains the queue, and app_rdy returns within 1 cycle of the first pop.
- Refresh: app_ref_req while 2 reads are queued -> both valids are returned, REFRESH lasts 8 cycles, app_ref_ack is a single pulse, and app_rdy=0 from req until ack+1.
- Assert rst with 3 reads in the pipe -> no app_rd_data_valid after reset. Re-calibration takes 64 cycles, and RAM data written before reset reads back intact.
